// File: rtl/bullet_engine_if.sv
// Bullet engine bus: battle/player side (master) and the bullet engine (slave).
interface bullet_engine_if;
    logic        start;
    logic [15:0] playerPos;
    logic [15:0] bulletPos;
    logic [2:0]  bulletColor;
    logic        hit;
    logic [7:0]  damage;
    logic        busy;
    logic        done;

    modport master (
        output start, playerPos,
        input  bulletPos, bulletColor, hit, damage, busy, done
    );

    modport slave (
        input  start, playerPos,
        output bulletPos, bulletColor, hit, damage, busy, done
    );
endinterface

// File: rtl/bullet_engine.sv
// Enemy bullet wave generator for the dodge phase: spawn, fall, collide, retire.
// Optional BULLET_HOMING_EN: bullet x drifts one unit toward the player on every tick.
module bullet_engine #(
    parameter int TICK_DIV = 1_000_000,
    parameter int BULLETS  = 8,
    parameter int X_MIN    = 64,
    parameter int Y_MIN    = 32,
    parameter int Y_MAX    = 160,
    parameter int SPEED    = 2,
    parameter int HIT_R    = 6,
    parameter int DMG_BASE = 2
) (
    input  logic clk,
    input  logic reset,
    bullet_engine_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SPAWN, MOVE, RETIRE, DONE} state_t;

    state_t        stateReg, stateNext;
    logic [15:0]   lfsrReg, lfsrNext;
    logic [7:0]    countReg, countNext;
    logic [TW-1:0] tickReg, tickNext;
    logic [7:0]    xReg, xNext;
    logic [7:0]    yReg, yNext;
    logic [2:0]    colorReg, colorNext;
    logic          hitReg, hitNext;
    logic [7:0]    damageReg, damageNext;
    logic          busyReg, busyNext;
    logic          doneReg, doneNext;

    logic [15:0] lfsrAdv;
    logic [2:0]  spawnColor;
    logic [8:0]  dx, dy, adx, ady;
    logic        collide;
    logic [7:0]  xStepped;

    assign lfsrAdv    = lfsrReg[0] ? ({1'b0, lfsrReg[15:1]} ^ 16'hB400) : {1'b0, lfsrReg[15:1]};
    assign spawnColor = (lfsrReg[10:8] == 3'd0) ? 3'd1 : lfsrReg[10:8];

    // 9-bit differences so a bullet near 0 never aliases a player near 255
    assign dx      = {1'b0, xReg} - {1'b0, bus.playerPos[15:8]};
    assign dy      = {1'b0, yReg} - {1'b0, bus.playerPos[7:0]};
    assign adx     = dx[8] ? -dx : dx;
    assign ady     = dy[8] ? -dy : dy;
    assign collide = (adx < 9'(HIT_R)) && (ady < 9'(HIT_R));

`ifdef BULLET_HOMING_EN
    always_comb begin
        xStepped = xReg;
        if (xReg > bus.playerPos[15:8])
            xStepped = xReg - 8'd1;
        else if (xReg < bus.playerPos[15:8])
            xStepped = xReg + 8'd1;
    end
`else
    assign xStepped = xReg;
`endif

    always_comb begin
        stateNext  = stateReg;
        lfsrNext   = lfsrReg;
        countNext  = countReg;
        tickNext   = tickReg;
        xNext      = xReg;
        yNext      = yReg;
        colorNext  = colorReg;
        hitNext    = 1'b0;
        damageNext = 8'd0;
        busyNext   = busyReg;
        doneNext   = 1'b0;

        case (stateReg)
            IDLE: begin
                if (bus.start) begin
                    stateNext = SPAWN;
                    busyNext  = 1'b1;
                end
            end
            SPAWN: begin
                xNext     = 8'(X_MIN) + {1'b0, lfsrReg[6:0]};
                yNext     = 8'(Y_MIN);
                colorNext = spawnColor;
                countNext = countReg + 8'd1;
                lfsrNext  = lfsrAdv;
                tickNext  = '0;
                stateNext = MOVE;
            end
            MOVE: begin
                // hit outranks the bottom check so a simultaneous case reports once
                if (collide) begin
                    hitNext    = 1'b1;
                    damageNext = 8'(DMG_BASE) + {5'd0, colorReg};
                    stateNext  = RETIRE;
                end else if (yReg >= 8'(Y_MAX)) begin
                    stateNext = RETIRE;
                end else if (tickReg == TW'(TICK_DIV - 1)) begin
                    tickNext = '0;
                    yNext    = yReg + 8'(SPEED);
                    xNext    = xStepped;
                end else begin
                    tickNext = tickReg + TW'(1);
                end
            end
            RETIRE: begin
                colorNext = 3'd0;
                stateNext = (countReg < 8'(BULLETS)) ? SPAWN : DONE;
            end
            DONE: begin
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                countNext = 8'd0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg  <= IDLE;
            lfsrReg   <= 16'hACE1;
            countReg  <= 8'd0;
            tickReg   <= '0;
            xReg      <= 8'd0;
            yReg      <= 8'd0;
            colorReg  <= 3'd0;
            hitReg    <= 1'b0;
            damageReg <= 8'd0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            lfsrReg   <= lfsrNext;
            countReg  <= countNext;
            tickReg   <= tickNext;
            xReg      <= xNext;
            yReg      <= yNext;
            colorReg  <= colorNext;
            hitReg    <= hitNext;
            damageReg <= damageNext;
            busyReg   <= busyNext;
            doneReg   <= doneNext;
        end
    end

    assign bus.bulletPos   = {xReg, yReg};
    assign bus.bulletColor = colorReg;
    assign bus.hit         = hitReg;
    assign bus.damage      = damageReg;
    assign bus.busy        = busyReg;
    assign bus.done        = doneReg;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine with TICK_DIV=4, BULLETS=2.
module tb_bullet_engine;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bullet_engine_if bus ();

    bullet_engine #(.TICK_DIV(4), .BULLETS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // returns at the negedge just after the edge that sampled start
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(1);
    endtask

    task automatic test_reset();
        bus.start     = 1'b0;
        bus.playerPos = 16'h0000;
        reset         = 1'b0;
        cycles(3);
        total++;
        if (bus.bulletPos !== 16'h0000 || bus.bulletColor !== 3'd0 || bus.hit !== 1'b0 ||
            bus.damage !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got pos=%h col=%0d hit=%b dmg=%0d busy=%b done=%b want all 0",
                     bus.bulletPos, bus.bulletColor, bus.hit, bus.damage, bus.busy, bus.done);
        end
        reset = 1'b1;
        cycles(1);
        $display("test_reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_first_spawn();
        pulse_start();
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start got=%b want=1", bus.busy);
        end
        cycles(1);
        total++;
        if (bus.bulletPos !== {8'd161, 8'd32}) begin
            bad++;
            $display("FAIL first_pos got=%h want=%h", bus.bulletPos, {8'd161, 8'd32});
        end
        total++;
        if (bus.bulletColor !== 3'd4) begin
            bad++;
            $display("FAIL first_color got=%0d want=4", bus.bulletColor);
        end
        $display("test_first_spawn: total=%0d bad=%0d", total, bad);
    endtask

    // entered at the first MOVE cycle of bullet 1
    task automatic test_retire();
        cycles(4);
        total++;
        if (bus.bulletPos[7:0] !== 8'd34) begin
            bad++;
            $display("FAIL first_tick_y got=%0d want=34", bus.bulletPos[7:0]);
        end
        cycles(251);
        total++;
        if (bus.bulletPos[7:0] !== 8'd158) begin
            bad++;
            $display("FAIL y_before_bottom got=%0d want=158", bus.bulletPos[7:0]);
        end
        cycles(1);
        total++;
        if (bus.bulletPos[7:0] !== 8'd160 || bus.bulletColor !== 3'd4) begin
            bad++;
            $display("FAIL y_at_bottom got y=%0d col=%0d want y=160 col=4", bus.bulletPos[7:0], bus.bulletColor);
        end
        cycles(2);
        total++;
        if (bus.bulletColor !== 3'd0) begin
            bad++;
            $display("FAIL retire_color got=%0d want=0", bus.bulletColor);
        end
        cycles(1);
        total++;
        if (bus.bulletPos !== {8'd176, 8'd32} || bus.bulletColor !== 3'd2) begin
            bad++;
            $display("FAIL second_spawn got pos=%h col=%0d want pos=%h col=2",
                     bus.bulletPos, bus.bulletColor, {8'd176, 8'd32});
        end
        $display("test_retire: total=%0d bad=%0d", total, bad);
    endtask

    // entered at the first MOVE cycle of bullet 2 (the last of the wave)
    task automatic test_done();
        int dones = 0;
        cycles(10);
        pulse_start();
        for (int i = 11; i <= 265; i++) begin
            if (bus.done === 1'b1) dones++;
            if (i == 258) begin
                total++;
                if (bus.bulletColor !== 3'd0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL pre_done got col=%0d done=%b busy=%b want col=0 done=0 busy=1",
                             bus.bulletColor, bus.done, bus.busy);
                end
            end
            if (i == 259) begin
                total++;
                if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL done_pulse got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
                end
            end
            if (i == 265) begin
                total++;
                if (bus.busy !== 1'b0 || bus.bulletColor !== 3'd0) begin
                    bad++;
                    $display("FAIL idle_after_done got busy=%b col=%0d want busy=0 col=0", bus.busy, bus.bulletColor);
                end
            end
            @(negedge clk);
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL done_count got=%0d want=1", dones);
        end
        $display("test_done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_reset_midwave();
        reset_pulse();
        pulse_start();
        cycles(20);
        reset = 1'b0;
        #1;
        total++;
        if (bus.bulletPos !== 16'h0000 || bus.bulletColor !== 3'd0 || bus.hit !== 1'b0 ||
            bus.damage !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL midwave_reset got pos=%h col=%0d hit=%b dmg=%0d busy=%b done=%b want all 0",
                     bus.bulletPos, bus.bulletColor, bus.hit, bus.damage, bus.busy, bus.done);
        end
        cycles(2);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL midwave_no_done got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        reset = 1'b1;
        cycles(1);
        pulse_start();
        cycles(1);
        total++;
        if (bus.bulletPos !== {8'd161, 8'd32} || bus.bulletColor !== 3'd4) begin
            bad++;
            $display("FAIL restart_spawn got pos=%h col=%0d want pos=%h col=4",
                     bus.bulletPos, bus.bulletColor, {8'd161, 8'd32});
        end
        $display("test_reset_midwave: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_hit();
        int hits = 0;
        reset_pulse();
        bus.playerPos = {8'd161, 8'd40};
        pulse_start();
        cycles(1);
        for (int i = 0; i <= 14; i++) begin
            if (bus.hit === 1'b1) hits++;
            if (i == 8) begin
                total++;
                if (bus.hit !== 1'b0 || bus.bulletPos[7:0] !== 8'd36) begin
                    bad++;
                    $display("FAIL hit_detect_cycle got hit=%b y=%0d want hit=0 y=36", bus.hit, bus.bulletPos[7:0]);
                end
            end
            if (i == 9) begin
                total++;
                if (bus.hit !== 1'b1 || bus.damage !== 8'd6 || bus.bulletColor !== 3'd4) begin
                    bad++;
                    $display("FAIL hit_pulse got hit=%b dmg=%0d col=%0d want hit=1 dmg=6 col=4",
                             bus.hit, bus.damage, bus.bulletColor);
                end
            end
            if (i == 10) begin
                total++;
                if (bus.hit !== 1'b0 || bus.damage !== 8'd0 || bus.bulletColor !== 3'd0) begin
                    bad++;
                    $display("FAIL hit_retire got hit=%b dmg=%0d col=%0d want 0 0 0",
                             bus.hit, bus.damage, bus.bulletColor);
                end
            end
            if (i == 11) begin
                total++;
                if (bus.bulletPos !== {8'd176, 8'd32} || bus.bulletColor !== 3'd2) begin
                    bad++;
                    $display("FAIL hit_next_spawn got pos=%h col=%0d want pos=%h col=2",
                             bus.bulletPos, bus.bulletColor, {8'd176, 8'd32});
                end
            end
            @(negedge clk);
        end
        total++;
        if (hits != 1) begin
            bad++;
            $display("FAIL hit_count got=%0d want=1", hits);
        end
        $display("test_hit: total=%0d bad=%0d", total, bad);
    endtask

`ifdef BULLET_HOMING_EN
    task automatic test_homing();
        logic [7:0] want;
        reset_pulse();
        bus.playerPos = {8'd150, 8'd0};
        pulse_start();
        cycles(1);
        for (int k = 1; k <= 15; k++) begin
            cycles(4);
            want = (161 - k > 150) ? 8'(161 - k) : 8'd150;
            total++;
            if (bus.bulletPos[15:8] !== want) begin
                bad++;
                $display("FAIL homing_x tick=%0d got=%0d want=%0d", k, bus.bulletPos[15:8], want);
            end
        end
        $display("test_homing: total=%0d bad=%0d", total, bad);
    endtask
`endif

    initial begin
        test_reset();
        test_first_spawn();
        test_retire();
        test_done();
        test_reset_midwave();
        test_hit();
`ifdef BULLET_HOMING_EN
        test_homing();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bullet_engine.md
# bullet_engine

Generates the enemy bullet for the dodge phase of a battle turn. Consumes `playerPos` from the player block and drives `bulletPos`/`bulletColor` into the VGA renderer. Reports collisions as a damage pulse to the battle state machine. One bullet is live at a time; a wave of `BULLETS` bullets is spawned sequentially after `start`, and the block pulses `done` when the wave ends.

## Interface

Parameters:
- `TICK_DIV`, 1_000_000: clk cycles per movement step; must be ≥1.
- `BULLETS`, 8: bullets per wave, 1..255.
- `X_MIN`, 64: left edge of the spawn band; spawn x = `X_MIN` + 0..127.
- `Y_MIN`, 32: spawn row.
- `Y_MAX`, 160: retire row; a bullet retires when y ≥ `Y_MAX`.
- `SPEED`, 2: y increment per step.
- `HIT_R`, 6: collision half-width, in coordinate units.
- `DMG_BASE`, 2: damage = `DMG_BASE` + bullet colour.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a wave when idle.
- `playerPos`  in  16  {x[15:8], y[7:0]} player centre.
- `bulletPos`  out  16  {x[15:8], y[7:0]} bullet centre.
- `bulletColor`  out  3  0 = no bullet drawn; 1..7 = palette index.
- `hit`  out  1  one-cycle pulse on collision.
- `damage`  out  8  valid while `hit`=1; otherwise 0.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at wave end.

## Operation

- Reset values: all outputs 0. State IDLE. LFSR = 16'hACE1. Bullet counter = 0. Tick counter = 0.
- LFSR: 16-bit Galois, mask 16'hB400 (shift right; if the shifted-out bit is 1, XOR with the mask). It advances only in SPAWN.
- IDLE: when `start`=1, go to SPAWN. `start` is ignored in every other state.
- SPAWN (1 cycle), using the current LFSR value L:
  - x = `X_MIN` + L[6:0]; y = `Y_MIN`.
  - colour = L[10:8]; a value of 0 is forced to 1.
  - Increment the bullet counter, advance the LFSR, clear the tick counter, go to MOVE.
- MOVE:
  - The tick counter counts 0..`TICK_DIV`-1. On wrap, y ← y + `SPEED` (8-bit; the `Y_MAX` check precedes any wrap).
  - Collision is checked every cycle against the registered positions: |bx−px| < `HIT_R` and |by−py| < `HIT_R`. Differences are computed at 9 bits to avoid wrap.
  - On collision: `hit`=1 and `damage`=`DMG_BASE`+colour for one cycle; the bullet retires.
  - Otherwise, if y ≥ `Y_MAX`, the bullet retires silently.
  - Collision and bottom in the same cycle: the hit wins and is reported once.
- Retire: `bulletColor` ← 0 on the next cycle. If counter < `BULLETS`, go to SPAWN; else go to DONE.
- DONE (1 cycle): `done`=1, `busy`=0, counter ← 0, go to IDLE. The LFSR is not reset, so the next wave continues the sequence.
- Reset asserted mid-wave: immediate return to reset values; no `done` pulse.

## Timing

- `start` sampled at edge N → SPAWN during cycle N+1, `busy`=1 from N+1 → position and colour valid at N+2.
- Hit detected in cycle K → `hit`/`damage` registered, visible in cycle K+1. `bulletColor`=0 in cycle K+2. Next SPAWN outputs appear in K+3.
- Position is stable between ticks. The renderer may sample it at any time.
- `done` is visible exactly 1 cycle after the last bullet's `bulletColor` goes to 0.

## Configuration

- `BULLET_HOMING_EN` defined: on each tick, x also steps by 1 toward the player x (no step when equal).
- Not defined: x is constant for a bullet's lifetime, and the homing comparator is not built.

## Test plan

- Reset, then `start` (`TICK_DIV`=4, `playerPos`=16'h0000) → first bullet `bulletPos`={8'd161, 8'd32}, `bulletColor`=4. `busy`=1.
- Same setup, no collision → y reaches 160 after 64 ticks (256 cycles). The bullet retires, and the second bullet spawns with x/colour taken from the advanced LFSR.
- `playerPos`={8'd161, 8'd40} → `hit` pulses exactly once with `damage`=6. `bulletColor`=0 two cycles after detection.
- `BULLETS`=2, no hits → exactly one `done` pulse after the second retire. `busy` falls together with `done`. A `start` during `busy` is ignored.
- Assert `reset` in the middle of MOVE → all outputs 0 immediately. A fresh `start` reproduces the first-bullet values (161, 32, colour 4).
- With `BULLET_HOMING_EN` and player x=150 → bullet x decrements by 1 per tick until it reaches 150, then holds.
